// File: rtl/bp_pkg.sv
// bp_pkg: shared types and constants for the branch resolve controller
package bp_pkg;
  localparam int INDEX_W = 6;
  localparam logic [31:0] PC_STEP = 32'd4;
  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic               pred_taken;
    logic [31:0]        pc;
  } bp_entry_t;
  typedef enum logic {IDLE, RECOVER} bp_state_e;
endpackage

// File: rtl/bp_inflight_fifo.sv
// bp_inflight_fifo: in-order queue of predicted branches awaiting resolution
module bp_inflight_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  bp_entry_t din,
  output bp_entry_t head,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  bp_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic wr_en, rd_en;
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign head  = mem[rd_ptr];
  assign wr_en = push & ~full & ~flush;
  assign rd_en = pop & ~empty & ~flush;
  // pointer and occupancy tracking; flush drops everything including a same-cycle push
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      wr_ptr <= wr_en ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= rd_en ? rd_ptr + 1'b1 : rd_ptr;
      count  <= count + CW'(wr_en) - CW'(rd_en);
    end
  end
  // entry storage, no reset needed since count gates visibility
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: resolves predicted branches, updates the PHT and redirects on mispredict
module branch_resolve_ctrl #(
  parameter int INDEX_W = 6,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               fetch_valid,
  input  logic [INDEX_W-1:0] fetch_index,
  input  logic               fetch_pred_taken,
  input  logic [31:0]        fetch_pc,
  input  logic               resolve_valid,
  input  logic               resolve_taken,
  input  logic [31:0]        resolve_target,
  output logic               full,
  output logic               upd_enable,
  output logic [INDEX_W-1:0] upd_index,
  output logic               upd_taken,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  output logic [31:0]        mispredict_cnt,
  output logic               underflow_err
);
  import bp_pkg::*;
  bp_state_e state;
  bp_entry_t head, din;
  logic empty, idle, push, pop, mis;
  assign idle = state == IDLE;
  assign pop  = resolve_valid & ~empty & idle;
  assign mis  = pop & (resolve_taken != head.pred_taken);
  assign push = fetch_valid & ~full & idle;
  assign din  = '{index: fetch_index, pred_taken: fetch_pred_taken, pc: fetch_pc};
  bp_inflight_fifo #(.DEPTH(DEPTH)) fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(push),
    .pop(pop),
    .flush(mis),
    .din(din),
    .head(head),
    .full(full),
    .empty(empty)
  );
  // registered update/redirect strobes, recovery state and error/statistics counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      upd_enable     <= 1'b0;
      upd_index      <= '0;
      upd_taken      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      mispredict_cnt <= '0;
      underflow_err  <= 1'b0;
    end else begin
      state          <= mis ? RECOVER : IDLE;
      upd_enable     <= pop;
      upd_index      <= pop ? head.index : '0;
      upd_taken      <= pop & resolve_taken;
      redirect_valid <= mis;
      redirect_pc    <= mis ? (resolve_taken ? resolve_target : head.pc + PC_STEP) : '0;
      if (mis && ~&mispredict_cnt) mispredict_cnt <= mispredict_cnt + 32'd1;
      if (resolve_valid && empty && idle) underflow_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed and randomized checks against a queue-based reference model
module tb_branch_resolve_ctrl;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset_n, fetch_valid, fetch_pred_taken, resolve_valid, resolve_taken;
  logic [5:0] fetch_index;
  logic [31:0] fetch_pc, resolve_target;
  logic full, upd_enable, upd_taken, redirect_valid, underflow_err;
  logic [5:0] upd_index;
  logic [31:0] redirect_pc, mispredict_cnt;
  int vec = 0;
  int err = 0;

  branch_resolve_ctrl #(.INDEX_W(6), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_valid(fetch_valid), .fetch_index(fetch_index),
    .fetch_pred_taken(fetch_pred_taken), .fetch_pc(fetch_pc),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .resolve_target(resolve_target), .full(full),
    .upd_enable(upd_enable), .upd_index(upd_index), .upd_taken(upd_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mispredict_cnt(mispredict_cnt), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  idx;
    logic        pt;
    logic [31:0] pc;
  } ent_t;
  ent_t q[$];
  bit m_rec, m_under;
  logic [31:0] m_cnt;
  logic e_en, e_tk, e_rv;
  logic [5:0] e_idx;
  logic [31:0] e_rpc;

  // reference: one call per clock edge, using the inputs currently driven
  task automatic model_step();
    ent_t h;
    bit mis, was_full;
    e_en = 0; e_tk = 0; e_rv = 0; e_idx = '0; e_rpc = '0;
    if (!reset_n) begin
      q.delete(); m_rec = 0; m_under = 0; m_cnt = '0;
      return;
    end
    mis = 0;
    was_full = q.size() == DEPTH;
    if (!m_rec) begin
      if (resolve_valid) begin
        if (q.size() == 0) m_under = 1;
        else begin
          h = q.pop_front();
          e_en = 1; e_idx = h.idx; e_tk = resolve_taken;
          if (resolve_taken != h.pt) begin
            mis = 1; e_rv = 1;
            e_rpc = resolve_taken ? resolve_target : h.pc + 32'd4;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            q.delete();
          end
        end
      end
      if (fetch_valid && !was_full && !mis) q.push_back('{fetch_index, fetch_pred_taken, fetch_pc});
    end
    m_rec = mis;
  endtask

  task automatic drive(input logic rn, input logic fv, input logic [5:0] fi, input logic fpt,
                       input logic [31:0] fpc, input logic rv, input logic rt, input logic [31:0] rtg);
    reset_n = rn; fetch_valid = fv; fetch_index = fi; fetch_pred_taken = fpt; fetch_pc = fpc;
    resolve_valid = rv; resolve_taken = rt; resolve_target = rtg;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [5:0] i, input logic pt, input logic [31:0] pc);
    drive(1, 1, i, pt, pc, 0, 0, 0);
  endtask

  task automatic resolve(input logic t, input logic [31:0] tg);
    drive(1, 0, 0, 0, 0, 1, t, tg);
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    vec += 5;
    if (upd_enable !== 1'b0) begin err++; $display("FAIL reset_upd_enable got %h want 0", upd_enable); end
    if (redirect_valid !== 1'b0) begin err++; $display("FAIL reset_redirect_valid got %h want 0", redirect_valid); end
    if (mispredict_cnt !== 32'd0) begin err++; $display("FAIL reset_mispredict_cnt got %h want 0", mispredict_cnt); end
    if (underflow_err !== 1'b0) begin err++; $display("FAIL reset_underflow got %h want 0", underflow_err); end
    if (full !== 1'b0) begin err++; $display("FAIL reset_full got %h want 0", full); end
  endtask

  task automatic test_correct();
    do_reset();
    fetch(6'd5, 1, 32'h100);
    resolve(1, 32'h0);
    vec += 5;
    if (upd_enable !== 1'b1) begin err++; $display("FAIL correct_upd_enable got %h want 1", upd_enable); end
    if (upd_index !== 6'd5) begin err++; $display("FAIL correct_upd_index got %h want 05", upd_index); end
    if (upd_taken !== 1'b1) begin err++; $display("FAIL correct_upd_taken got %h want 1", upd_taken); end
    if (redirect_valid !== 1'b0) begin err++; $display("FAIL correct_redirect got %h want 0", redirect_valid); end
    if (mispredict_cnt !== 32'd0) begin err++; $display("FAIL correct_mcnt got %h want 0", mispredict_cnt); end
    idle();
    vec++;
    if (upd_enable !== 1'b0) begin err++; $display("FAIL correct_strobe_single got %h want 0", upd_enable); end
  endtask

  task automatic test_mispredict();
    do_reset();
    fetch(6'd1, 1, 32'h200);
    fetch(6'd2, 0, 32'h204);
    fetch(6'd3, 0, 32'h208);
    drive(1, 1, 6'd4, 1, 32'h20C, 1, 0, 32'h0);
    vec += 4;
    if (redirect_valid !== 1'b1) begin err++; $display("FAIL mis_redirect_valid got %h want 1", redirect_valid); end
    if (redirect_pc !== 32'h204) begin err++; $display("FAIL mis_redirect_pc got %h want 00000204", redirect_pc); end
    if (mispredict_cnt !== 32'd1) begin err++; $display("FAIL mis_mcnt got %h want 1", mispredict_cnt); end
    if (upd_index !== 6'd1 || upd_taken !== 1'b0) begin err++; $display("FAIL mis_update got %h/%h want 01/0", upd_index, upd_taken); end
    fetch(6'd5, 1, 32'h500);
    vec++;
    if (redirect_valid !== 1'b0 || upd_enable !== 1'b0) begin err++; $display("FAIL mis_recover_quiet got %h/%h want 0/0", redirect_valid, upd_enable); end
    fetch(6'd9, 1, 32'h300);
    resolve(1, 32'h0);
    vec++;
    if (upd_index !== 6'd9 || upd_enable !== 1'b1) begin err++; $display("FAIL mis_flushed_head got %h/%h want 09/1", upd_index, upd_enable); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) fetch(6'(10 + i), 1, 32'h1000 + 32'(4 * i));
    vec++;
    if (full !== 1'b1) begin err++; $display("FAIL full_set got %h want 1", full); end
    fetch(6'd14, 1, 32'h2000);
    vec++;
    if (full !== 1'b1) begin err++; $display("FAIL full_hold got %h want 1", full); end
    drive(1, 1, 6'd15, 1, 32'h3000, 1, 1, 32'h0);
    vec += 2;
    if (upd_index !== 6'd10) begin err++; $display("FAIL full_pop0 got %h want 0a", upd_index); end
    if (full !== 1'b0) begin err++; $display("FAIL full_blocked_push got %h want 0", full); end
    for (int i = 0; i < 3; i++) begin
      resolve(1, 32'h0);
      vec++;
      if (upd_index !== 6'(11 + i) || upd_enable !== 1'b1) begin err++; $display("FAIL full_order%0d got %h want %h", i, upd_index, 6'(11 + i)); end
    end
    idle();
    vec++;
    if (underflow_err !== 1'b0) begin err++; $display("FAIL full_no_underflow got %h want 0", underflow_err); end
  endtask

  task automatic test_underflow();
    do_reset();
    resolve(1, 32'h0);
    vec += 2;
    if (upd_enable !== 1'b0) begin err++; $display("FAIL uf_no_update got %h want 0", upd_enable); end
    if (underflow_err !== 1'b1) begin err++; $display("FAIL uf_set got %h want 1", underflow_err); end
    fetch(6'd2, 1, 32'h40);
    resolve(1, 32'h0);
    idle();
    vec++;
    if (underflow_err !== 1'b1) begin err++; $display("FAIL uf_sticky got %h want 1", underflow_err); end
    do_reset();
    vec++;
    if (underflow_err !== 1'b0) begin err++; $display("FAIL uf_reset got %h want 0", underflow_err); end
  endtask

  task automatic test_targets();
    do_reset();
    fetch(6'd3, 0, 32'h40);
    resolve(1, 32'h3000);
    vec++;
    if (redirect_pc !== 32'h3000) begin err++; $display("FAIL tgt_taken got %h want 00003000", redirect_pc); end
    idle();
    fetch(6'd4, 1, 32'hFFFF_FFFC);
    resolve(0, 32'h1234);
    vec += 2;
    if (redirect_pc !== 32'h0) begin err++; $display("FAIL tgt_wrap got %h want 00000000", redirect_pc); end
    if (mispredict_cnt !== 32'd2) begin err++; $display("FAIL tgt_mcnt got %h want 2", mispredict_cnt); end
  endtask

  task automatic test_reset_recover();
    do_reset();
    fetch(6'd6, 1, 32'h80);
    resolve(0, 32'h0);
    vec++;
    if (redirect_valid !== 1'b1) begin err++; $display("FAIL rr_enter got %h want 1", redirect_valid); end
    drive(0, 1, 6'd8, 1, 32'h90, 0, 0, 0);
    vec++;
    if ({redirect_valid, upd_enable, full, redirect_pc, mispredict_cnt} !== '0) begin
      err++; $display("FAIL rr_cleared got rv=%h ue=%h f=%h pc=%h cnt=%h want all 0", redirect_valid, upd_enable, full, redirect_pc, mispredict_cnt);
    end
    fetch(6'd7, 1, 32'hA0);
    resolve(1, 32'h0);
    vec++;
    if (upd_enable !== 1'b1 || upd_index !== 6'd7) begin err++; $display("FAIL rr_resume got %h/%h want 1/07", upd_enable, upd_index); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(99) != 0, $urandom_range(9) < 6, 6'($urandom), 1'($urandom), $urandom,
            $urandom_range(9) < 4, 1'($urandom), $urandom);
      vec++;
      if (upd_enable !== e_en || upd_index !== e_idx || upd_taken !== e_tk || redirect_valid !== e_rv ||
          redirect_pc !== e_rpc || mispredict_cnt !== m_cnt || underflow_err !== m_under ||
          full !== (q.size() == DEPTH)) begin
        err++;
        $display("FAIL rand cyc %0d got en=%h idx=%h tk=%h rv=%h pc=%h cnt=%h uf=%h full=%h want en=%h idx=%h tk=%h rv=%h pc=%h cnt=%h uf=%h full=%h",
                 n, upd_enable, upd_index, upd_taken, redirect_valid, redirect_pc, mispredict_cnt, underflow_err, full,
                 e_en, e_idx, e_tk, e_rv, e_rpc, m_cnt, m_under, q.size() == DEPTH);
      end
    end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_mispredict();
    test_full();
    test_underflow();
    test_targets();
    test_reset_recover();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
